// File: rtl/clk_1hz_monitor.sv
// clk_1hz_monitor: synchronises a 1 Hz clock, measures its half-periods and tracks lock/errors.
// Latency: tick and status update 3 cycles after a clk_in transition; free-running, no backpressure.
module clk_1hz_monitor #(
  parameter int CLK_FREQ   = 50000000,
  parameter int TOL        = 1000,
  parameter int LOCK_COUNT = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             clk_in,
  output logic             tick,
  output logic             locked,
  output logic             err_pulse,
  output logic [15:0]      err_count,
  output logic [CNT_W-1:0] last_period,
  output logic             timeout
);

  localparam int HALF = CLK_FREQ / 2;
  localparam logic [CNT_W-1:0] M_LO  = CNT_W'(HALF - TOL);
  localparam logic [CNT_W-1:0] M_HI  = CNT_W'(HALF + TOL);
  localparam logic [CNT_W-1:0] H_SAT = CNT_W'(HALF + TOL + 1);
  localparam int GC_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [GC_W-1:0] GC_LOCK = GC_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_LOCKED
  } state_t;

  state_t           state, state_nxt;
  logic [GC_W-1:0]  good_cnt, good_cnt_nxt;
  logic             locked_nxt, timeout_nxt, err_nxt;
  logic             s1, s2, s3;
  logic             rise, fall, edge_cyc;
  logic             good, to_evt;
  logic [CNT_W-1:0] hcnt, pcnt;
  logic             period_vld;

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign edge_cyc = rise | fall;
  // hcnt in an edge cycle is the measured half-period
  assign good     = (hcnt >= M_LO) && (hcnt <= M_HI);
  assign to_evt   = (state != S_IDLE) && (hcnt == H_SAT) && !edge_cyc;

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      tick        <= 1'b0;
      hcnt        <= '0;
      pcnt        <= '0;
      last_period <= '0;
      period_vld  <= 1'b0;
    end else begin
      s1   <= clk_in;
      s2   <= s1;
      s3   <= s2;
      tick <= rise;

      if (edge_cyc)
        hcnt <= CNT_W'(1);
      else if (hcnt < H_SAT)
        hcnt <= hcnt + 1'b1;

      if (rise)
        pcnt <= CNT_W'(1);
      else if (pcnt != '1)
        pcnt <= pcnt + 1'b1;

      // A period is only reported once a full rise-to-rise span was observed since leaving IDLE
      if (rise) begin
        if (period_vld)
          last_period <= pcnt;
        period_vld <= 1'b1;
      end else if (to_evt) begin
        period_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state     <= S_IDLE;
      good_cnt  <= '0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      good_cnt  <= good_cnt_nxt;
      locked    <= locked_nxt;
      timeout   <= timeout_nxt;
      err_pulse <= err_nxt;
      if (err_nxt && (err_count != 16'hFFFF))
        err_count <= err_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    locked_nxt   = locked;
    timeout_nxt  = timeout;
    err_nxt      = 1'b0;
    case (state)
      S_IDLE: begin
        if (edge_cyc) begin
          state_nxt    = S_ACQ;
          good_cnt_nxt = '0;
          timeout_nxt  = 1'b0;
        end
      end
      S_ACQ: begin
        if (edge_cyc) begin
          if (good) begin
            good_cnt_nxt = good_cnt + 1'b1;
            if (good_cnt_nxt == GC_LOCK) begin
              state_nxt  = S_LOCKED;
              locked_nxt = 1'b1;
            end
          end else begin
            err_nxt      = 1'b1;
            good_cnt_nxt = '0;
          end
        end
      end
      S_LOCKED: begin
        if (edge_cyc && !good) begin
          err_nxt      = 1'b1;
          locked_nxt   = 1'b0;
          good_cnt_nxt = '0;
          state_nxt    = S_ACQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Edge has priority: to_evt is already qualified with no edge this cycle
    if (to_evt) begin
      err_nxt      = 1'b1;
      timeout_nxt  = 1'b1;
      locked_nxt   = 1'b0;
      good_cnt_nxt = '0;
      state_nxt    = S_IDLE;
    end
  end

endmodule

// File: tb/tb_clk_1hz_monitor.sv
// Bench for clk_1hz_monitor: directed half-period patterns plus random ones against a timestamp model.
module tb_clk_1hz_monitor;

  localparam int CLK_FREQ   = 100;
  localparam int TOL        = 2;
  localparam int LOCK_COUNT = 2;
  localparam int CNT_W      = 16;
  localparam int HALF       = CLK_FREQ / 2;
  localparam int SAT        = HALF + TOL + 1;

  logic             clk_50MHz = 1'b0;
  logic             rst       = 1'b1;
  logic             clk_in    = 1'b0;
  logic             tick, locked, err_pulse, timeout;
  logic [15:0]      err_count;
  logic [CNT_W-1:0] last_period;

  clk_1hz_monitor #(
    .CLK_FREQ  (CLK_FREQ),
    .TOL       (TOL),
    .LOCK_COUNT(LOCK_COUNT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .rst        (rst),
    .clk_in     (clk_in),
    .tick       (tick),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .last_period(last_period),
    .timeout    (timeout)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: clk_in sample history, event timestamps and a good-half streak
  logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
  bit   armed  = 1'b0;
  bit   pvalid = 1'b0;
  int   streak = 0;
  int   t_last = 0;
  int   t_rise = 0;
  logic e_tick = 1'b0, e_lock = 1'b0, e_err = 1'b0, e_to = 1'b0;
  int   e_cnt = 0;
  int   e_lp  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_error();
    e_err = 1'b1;
    if (e_cnt < 65535) e_cnt++;
  endtask

  task automatic model_edge(input logic din, input logic r);
    logic evt, rs;
    int   m;
    cyc++;
    e_tick = 1'b0;
    e_err  = 1'b0;
    if (r) begin
      h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
      armed = 1'b0; pvalid = 1'b0; streak = 0;
      t_last = cyc; t_rise = cyc;
      e_to = 1'b0; e_lp = 0; e_cnt = 0;
    end else begin
      // The monitor sees a clk_in transition three samples late
      evt = (h1 != h2);
      rs  = h1 & ~h2;
      h2 = h1; h1 = h0; h0 = din;
      if (evt) begin
        m = cyc - t_last;
        if (m > SAT) m = SAT;
        if (!armed) begin
          armed  = 1'b1;
          streak = 0;
          e_to   = 1'b0;
        end else if (m >= HALF - TOL && m <= HALF + TOL) begin
          streak++;
        end else begin
          streak = 0;
          model_error();
        end
        t_last = cyc;
        if (rs) begin
          if (pvalid) e_lp = (cyc - t_rise > 65535) ? 65535 : cyc - t_rise;
          pvalid = 1'b1;
          t_rise = cyc;
        end
        e_tick = rs;
      end else if (armed && (cyc - t_last == SAT)) begin
        model_error();
        armed  = 1'b0;
        streak = 0;
        pvalid = 1'b0;
        e_to   = 1'b1;
      end
    end
    e_lock = (streak >= LOCK_COUNT);
  endtask

  task automatic step(input logic din, input logic r);
    clk_in = din;
    rst    = r;
    @(posedge clk_50MHz);
    model_edge(din, r);
    #1;
    check("tick",        32'(tick),        32'(e_tick));
    check("locked",      32'(locked),      32'(e_lock));
    check("err_pulse",   32'(err_pulse),   32'(e_err));
    check("timeout",     32'(timeout),     32'(e_to));
    check("err_count",   32'(err_count),   32'(e_cnt));
    check("last_period", 32'(last_period), 32'(e_lp));
  endtask

  task automatic half(input logic lvl, input int n);
    for (int i = 0; i < n; i++) step(lvl, 1'b0);
  endtask

  task automatic periods(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      half(1'b1, hi);
      half(1'b0, lo);
    end
  endtask

  initial begin
    int   len;
    int   sel;
    logic lvl;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check("rst_locked",  32'(locked),      32'd0);
    check("rst_errcnt",  32'(err_count),   32'd0);
    check("rst_lastper", 32'(last_period), 32'd0);

    periods(10, 50, 50);
    check("ideal_lastper", 32'(last_period), 32'd100);
    check("ideal_locked",  32'(locked),      32'd1);
    check("ideal_errcnt",  32'(err_count),   32'd0);

    periods(2, 48, 52);
    periods(2, 52, 48);
    check("tolbound_locked", 32'(locked),    32'd1);
    check("tolbound_errcnt", 32'(err_count), 32'd0);

    half(1'b1, 47); half(1'b0, 50); half(1'b1, 50); half(1'b0, 50);
    check("short47_errcnt", 32'(err_count), 32'd1);
    check("short47_relock", 32'(locked),    32'd1);

    half(1'b1, 53); half(1'b0, 50); half(1'b1, 50); half(1'b0, 50);
    check("edge_at_sat_errcnt", 32'(err_count), 32'd2);
    check("edge_at_sat_relock", 32'(locked),    32'd1);

    half(1'b0, 100);
    check("stop_timeout", 32'(timeout),   32'd1);
    check("stop_locked",  32'(locked),    32'd0);
    check("stop_errcnt",  32'(err_count), 32'd3);

    periods(4, 50, 50);
    check("restart_timeout", 32'(timeout), 32'd0);
    check("restart_locked",  32'(locked),  32'd1);

    lvl = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      len = $urandom_range(HALF - TOL - 2, HALF + TOL + 2);
      else if (sel < 9) len = $urandom_range(1, 60);
      else              len = $urandom_range(SAT, SAT + 15);
      half(lvl, len);
      lvl = ~lvl;
    end

    periods(4, 50, 50);
    half(1'b1, 20);
    step(1'b1, 1'b1);
    check("midrst_locked",  32'(locked),      32'd0);
    check("midrst_errcnt",  32'(err_count),   32'd0);
    check("midrst_lastper", 32'(last_period), 32'd0);
    half(1'b0, 50);
    periods(3, 50, 50);
    check("postrst_locked",  32'(locked),      32'd1);
    check("postrst_lastper", 32'(last_period), 32'd100);

    for (int i = 0; i < 65600; i++) step(1'(i & 1), 1'b0);
    check("sat_errcnt", 32'(err_count), 32'hFFFF);
    check("sat_pulse",  32'(err_pulse), 32'd1);
    half(1'b0, 60);
    check("sat_hold", 32'(err_count), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
